// File: rtl/sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram_fifo_ctrl
//
// FIFO controller that stores words in an external simple dual-port SRAM
// (single clock, registered read data) and presents the head word to the
// downstream side through a small 2-entry output buffer.  The output buffer
// hides the one-cycle SRAM read latency, so that with out_ready_i held high
// one word leaves per clock in steady state.
//
// Ports
//   clk          single clock, shared with the SRAM (wrclk = rdclk = clk)
//   rst_n        asynchronous active-low reset
//   in_valid_i   upstream word valid
//   in_data_i    upstream word
//   in_ready_o   block can accept a word (SRAM not full)
//   out_valid_o  out_data_o holds a valid word
//   out_data_o   head word, shown ahead of the pop
//   out_ready_i  downstream accepts the head word
//   wren_o       SRAM write enable
//   wraddr_o     SRAM write address
//   wrdata_o     SRAM write data
//   rden_o       SRAM read enable
//   rdaddr_o     SRAM read address
//   rddata_i     SRAM read data, valid one edge after rden_o
//   count_o      total words held: SRAM + read in flight + output buffer
// ---------------------------------------------------------------------------
module sram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    in_valid_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    output logic                    in_ready_o,

    output logic                    out_valid_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    input  logic                    out_ready_i,

    output logic                    wren_o,
    output logic [ADDR_WIDTH-1:0]   wraddr_o,
    output logic [DATA_WIDTH-1:0]   wrdata_o,
    output logic                    rden_o,
    output logic [ADDR_WIDTH-1:0]   rdaddr_o,
    input  logic [DATA_WIDTH-1:0]   rddata_i,

    output logic [ADDR_WIDTH+1:0]   count_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SRAM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [ADDR_WIDTH:0]    sram_cnt;      // 0..DEPTH words resident in SRAM
    logic                   inflight;      // read issued last cycle, data arrives this edge
    logic [1:0]             obuf_cnt;      // 0..2 words in the output buffer
    logic                   obuf_head;     // index of the oldest output-buffer entry
    logic [DATA_WIDTH-1:0]  obuf [2];
    logic [ADDR_WIDTH+1:0]  count_q;

    // -----------------------------------------------------------------------
    // Handshake and read-issue decisions
    // -----------------------------------------------------------------------
    logic                   push;
    logic                   pop;
    logic                   rd_issue;
    logic                   capture;
    logic [1:0]             obuf_occ;      // buffer words plus the one in flight
    logic                   obuf_tail;

    logic [ADDR_WIDTH:0]    sram_cnt_nxt;
    logic [1:0]             obuf_cnt_nxt;
    logic [ADDR_WIDTH+1:0]  count_nxt;

    // Readiness looks only at SRAM occupancy, so it never depends on
    // out_ready_i.  A read issued this cycle frees a slot from the next one.
    assign in_ready_o  = (sram_cnt < SRAM_FULL);
    assign out_valid_o = (obuf_cnt != 2'd0);

    // Gating with rst_n keeps both SRAM strobes low while reset is asserted,
    // whatever the handshake inputs are doing.
    assign push    = rst_n & in_valid_i & in_ready_o;
    assign pop     = out_valid_o & out_ready_i;
    assign capture = inflight;

    // A read may be issued when, after this cycle's pop, the output buffer
    // still has room for the word already in flight plus the new one.
    assign obuf_occ = obuf_cnt + {1'b0, inflight};
    assign rd_issue = rst_n
                    & (sram_cnt != '0)
                    & ({1'b0, obuf_occ} < (3'd2 + {2'b0, pop}));

    // The write slot is the entry after the head when one word is held,
    // and the head itself when the buffer is empty.  A capture never meets
    // a full buffer because issue is throttled on buffer occupancy.
    assign obuf_tail = obuf_head ^ obuf_cnt[0];

    // -----------------------------------------------------------------------
    // SRAM interface: write strobes are combinational in the accept cycle.
    // A write and a read never hit the same address: a read needs the word
    // to be resident already, and the write slot is by definition empty.
    // -----------------------------------------------------------------------
    assign wren_o   = push;
    assign wraddr_o = wr_ptr;
    assign wrdata_o = in_data_i;
    assign rden_o   = rd_issue;
    assign rdaddr_o = rd_ptr;

    assign out_data_o = obuf[obuf_head];
    assign count_o    = count_q;

    // -----------------------------------------------------------------------
    // Next-state arithmetic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        sram_cnt_nxt = sram_cnt;
        obuf_cnt_nxt = obuf_cnt;
        count_nxt    = count_q;

        // A push and a read issue in the same cycle cancel out.
        case ({push, rd_issue})
            2'b10:   sram_cnt_nxt = sram_cnt + 1'b1;
            2'b01:   sram_cnt_nxt = sram_cnt - 1'b1;
            default: sram_cnt_nxt = sram_cnt;
        endcase

        // A capture and a pop in the same cycle leave the buffer level alone.
        case ({capture, pop})
            2'b10:   obuf_cnt_nxt = obuf_cnt + 2'd1;
            2'b01:   obuf_cnt_nxt = obuf_cnt - 2'd1;
            default: obuf_cnt_nxt = obuf_cnt;
        endcase

        // Internal transfers (issue, capture) only move words around, so the
        // total changes only on the external push and pop.  This keeps the
        // registered count equal to sram_cnt + inflight + obuf_cnt.
        case ({push, pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of process order.
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sram_cnt  <= '0;
            inflight  <= 1'b0;
            obuf_cnt  <= 2'd0;
            obuf_head <= 1'b0;
            count_q   <= '0;
        end else begin
            // Pointers are ADDR_WIDTH bits wide, so they wrap from DEPTH-1
            // to 0 naturally.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop) begin
                obuf_head <= ~obuf_head;
            end
            inflight <= rd_issue;
            sram_cnt <= sram_cnt_nxt;
            obuf_cnt <= obuf_cnt_nxt;
            count_q  <= count_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the two buffer entries are ordinary flops and are cleared so
        // out_data_o reads 0 out of reset; the SRAM array itself is never
        // cleared, since obuf_cnt and sram_cnt already mark it empty.
        if (!rst_n) begin
            obuf[0] <= '0;
            obuf[1] <= '0;
        end else if (capture) begin
            obuf[obuf_tail] <= rddata_i;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//
// Bench for sram_fifo_ctrl with ADDR_WIDTH=2 (DEPTH=4), DATA_WIDTH=16 and a
// behavioural simple dual-port SRAM with registered read data.  A scoreboard
// queue receives every accepted word; a negedge monitor pops and compares on
// every downstream pop and tracks expected SRAM addresses and count_o.
// Inputs are driven 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_sram_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 16;
    localparam int CW = AW + 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready;
    logic          wren_o;
    logic [AW-1:0] wraddr_o;
    logic [DW-1:0] wrdata_o;
    logic          rden_o;
    logic [AW-1:0] rdaddr_o;
    logic [DW-1:0] rddata;
    logic [CW-1:0] count_o;

    sram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready),
        .wren_o      (wren_o),
        .wraddr_o    (wraddr_o),
        .wrdata_o    (wrdata_o),
        .rden_o      (rden_o),
        .rdaddr_o    (rdaddr_o),
        .rddata_i    (rddata),
        .count_o     (count_o)
    );

    // Simple dual-port SRAM, registered read.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (wren_o) mem[wraddr_o] <= wrdata_o;
        if (rden_o) rddata <= mem[rdaddr_o];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    // Scoreboard and address model
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] exp_wa;
    logic [AW-1:0] exp_ra;
    bit            mon_en;

    always @(negedge clk) begin
        logic [DW-1:0] exp_d;
        logic          exp_wren;
        if (rst_n && mon_en) begin
            n_tests++;
            if (count_o !== CW'(exp_q.size())) begin
                n_fail++;
                $display("FAIL mon_count: got %0d want %0d at %0t", count_o, exp_q.size(), $time);
            end

            exp_wren = in_valid && in_ready_o;
            n_tests++;
            if (wren_o !== exp_wren || (exp_wren && wraddr_o !== exp_wa)) begin
                n_fail++;
                $display("FAIL mon_write: wren=%0b addr=%0d want wren=%0b addr=%0d at %0t",
                         wren_o, wraddr_o, exp_wren, exp_wa, $time);
            end
            if (exp_wren) begin
                exp_q.push_back(in_data);
                exp_wa++;
            end

            if (rden_o) begin
                n_tests++;
                if (rdaddr_o !== exp_ra || (wren_o && wraddr_o == rdaddr_o)) begin
                    n_fail++;
                    $display("FAIL mon_read: rdaddr=%0d want %0d wren=%0b wraddr=%0d at %0t",
                             rdaddr_o, exp_ra, wren_o, wraddr_o, $time);
                end
                exp_ra++;
            end

            if (out_valid_o && out_ready) begin
                n_pops++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_pop: got 0x%04h want nothing (queue empty) at %0t", out_data_o, $time);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (out_data_o !== exp_d) begin
                        n_fail++;
                        $display("FAIL mon_pop: got 0x%04h want 0x%04h at %0t", out_data_o, exp_d, $time);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_wa = '0;
        exp_ra = '0;
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        clear_model();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic push_word(input logic [DW-1:0] d);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (in_ready_o) begin
                accepted = 1'b1;
                break;
            end
            step();
        end
        n_tests++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL push_timeout: word 0x%04h got in_ready=0 want 1", d);
        end else begin
            step();
        end
        in_valid = 1'b0;
    endtask

    // Pop everything with out_ready held high (bounded).
    task automatic drain();
        bit empty = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (count_o == '0 && !out_valid_o) begin
                empty = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        n_tests++;
        if (!empty || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: count=%0d queue=%0d want 0 and 0", count_o, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        out_ready = 1'b1;
        mon_en    = 1'b0;
        clear_model();
        #3;
        n_tests++;
        if (out_valid_o !== 1'b0 || count_o !== '0 || in_ready_o !== 1'b1 ||
            wren_o !== 1'b0 || rden_o !== 1'b0 || out_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ov=%0b cnt=%0d ir=%0b wren=%0b rden=%0b od=0x%04h want 0 0 1 0 0 0x0000",
                     out_valid_o, count_o, in_ready_o, wren_o, rden_o, out_data_o);
        end
        step();
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        mon_en    = 1'b1;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00A5;
        #1;
        n_tests++;
        if (wren_o !== 1'b1 || wraddr_o !== 2'd0 || wrdata_o !== 16'h00A5 || rden_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_write: wren=%0b addr=%0d data=0x%04h rden=%0b want 1 0 0x00a5 0",
                     wren_o, wraddr_o, wrdata_o, rden_o);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if (rden_o !== 1'b1 || rdaddr_o !== 2'd0 || out_valid_o !== 1'b0 || count_o !== 4'd1) begin
            n_fail++;
            $display("FAIL single_read: rden=%0b addr=%0d ov=%0b cnt=%0d want 1 0 0 1",
                     rden_o, rdaddr_o, out_valid_o, count_o);
        end
        step();
        n_tests++;
        if (rden_o !== 1'b0 || out_valid_o !== 1'b0 || count_o !== 4'd1) begin
            n_fail++;
            $display("FAIL single_inflight: rden=%0b ov=%0b cnt=%0d want 0 0 1", rden_o, out_valid_o, count_o);
        end
        step();
        n_tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h00A5 || count_o !== 4'd1) begin
            n_fail++;
            $display("FAIL single_out: ov=%0b data=0x%04h cnt=%0d want 1 0x00a5 1", out_valid_o, out_data_o, count_o);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid_o !== 1'b0 || count_o !== 4'd0) begin
            n_fail++;
            $display("FAIL single_pop: ov=%0b cnt=%0d want 0 0", out_valid_o, count_o);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) push_word(16'(k));
        in_valid = 1'b1;
        in_data  = 16'd7;
        for (int i = 0; i < 4; i++) step();
        n_tests++;
        if (in_ready_o !== 1'b0 || count_o !== 4'd6 || out_valid_o !== 1'b1 || out_data_o !== 16'd1) begin
            n_fail++;
            $display("FAIL fill_full: ir=%0b cnt=%0d ov=%0b data=%0d want 0 6 1 1",
                     in_ready_o, count_o, out_valid_o, out_data_o);
        end
        // One pop frees space; word 7 then goes in.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        push_word(16'd7);
        drain();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            bit exp_v;
            in_valid = (c < 20);
            in_data  = 16'(c);
            exp_v    = (c >= 3) && (c < 23);
            n_tests++;
            if (out_valid_o !== exp_v || (exp_v && out_data_o !== 16'(c - 3)) || count_o > 4'd3) begin
                n_fail++;
                $display("FAIL stream_c%0d: ov=%0b data=%0d cnt=%0d want ov=%0b data=%0d cnt<=3",
                         c, out_valid_o, out_data_o, count_o, exp_v, c - 3);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (count_o !== '0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_end: cnt=%0d queue=%0d want 0 0", count_o, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int idx = 0;
        do_reset();
        n_pops = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit acc;
            if (idx == 10 && count_o == '0) break;
            out_ready = (idx == 10) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (idx < 10) && ($urandom_range(0, 2) != 0);
            in_data   = 16'h0100 + 16'(idx);
            acc       = in_valid && in_ready_o;
            step();
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (idx != 10 || n_pops != 10 || count_o !== '0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap: pushed=%0d popped=%0d cnt=%0d want 10 10 0", idx, n_pops, count_o);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_word(16'h0200 + 16'(k));
        step();
        step();
        n_tests++;
        if (count_o !== 4'd4 || out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: cnt=%0d ov=%0b want 4 1", count_o, out_valid_o);
        end
        mon_en   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0055;
        rst_n    = 1'b0;
        #1;
        n_tests++;
        if (out_valid_o !== 1'b0 || count_o !== '0 || in_ready_o !== 1'b1 ||
            wren_o !== 1'b0 || rden_o !== 1'b0 || out_data_o !== '0) begin
            n_fail++;
            $display("FAIL rmid_async: ov=%0b cnt=%0d ir=%0b wren=%0b rden=%0b od=0x%04h want 0 0 1 0 0 0x0000",
                     out_valid_o, count_o, in_ready_o, wren_o, rden_o, out_data_o);
        end
        step();
        clear_model();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        #1;
        n_tests++;
        if (wren_o !== 1'b1 || wraddr_o !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_first_write: wren=%0b addr=%0d want 1 0", wren_o, wraddr_o);
        end
        step();
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        mon_en    = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, giving the SRAM address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, giving the word width.
REQ-003 SHALL have port clk  input  1  the single clock; the block and the attached simple dual-port SRAM run on it (SRAM wrclk = rdclk = clk).
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid_i  input  1  upstream word valid.
REQ-006 SHALL have port in_data_i  input  DATA_WIDTH  upstream word.
REQ-007 SHALL have port in_ready_o  output  1  the block can accept a word.
REQ-008 SHALL have port out_valid_o  output  1  out_data_o holds a valid word.
REQ-009 SHALL have port out_data_o  output  DATA_WIDTH  head word, shown ahead of the pop.
REQ-010 SHALL have port out_ready_i  input  1  downstream accepts the word.
REQ-011 SHALL have port wren_o  output  1  SRAM write enable.
REQ-012 SHALL have port wraddr_o  output  ADDR_WIDTH  SRAM write address.
REQ-013 SHALL have port wrdata_o  output  DATA_WIDTH  SRAM write data.
REQ-014 SHALL have port rden_o  output  1  SRAM read enable.
REQ-015 SHALL have port rdaddr_o  output  ADDR_WIDTH  SRAM read address.
REQ-016 SHALL have port rddata_i  input  DATA_WIDTH  SRAM registered read data, valid one edge after rden_o.
REQ-017 SHALL have port count_o  output  ADDR_WIDTH+2  total words held (SRAM + read in flight + output buffer), range 0..DEPTH+2.

Function
REQ-018 Push: a word is accepted when in_valid_i and in_ready_o are both high at a rising edge; in_ready_o SHALL equal (sram_cnt < DEPTH).
REQ-019 On accept, wren_o=1, wraddr_o=wr_ptr and wrdata_o=in_data_i SHALL be driven combinationally in the same cycle; wr_ptr SHALL increment modulo DEPTH.
REQ-020 Output buffer SHALL be a 2-entry FIFO (obuf_cnt 0..2); out_valid_o = (obuf_cnt != 0); out_data_o = oldest entry.
REQ-021 Pop: occurs when out_valid_o and out_ready_i are both high at a rising edge; it removes the oldest entry.
REQ-022 Read issue: rden_o=1 with rdaddr_o=rd_ptr SHALL be driven when sram_cnt != 0 and (obuf_cnt + inflight - pop) < 2; rd_ptr SHALL increment modulo DEPTH; the inflight flag SHALL be set for exactly the following cycle.
REQ-023 Capture: when inflight=1, rddata_i SHALL be written into the output buffer at that edge; a simultaneous pop and capture SHALL leave obuf_cnt unchanged.
REQ-024 sram_cnt SHALL be +1 on push only, -1 on read issue only, and unchanged when both occur in the same cycle.
REQ-025 Latency: a word accepted at edge E0 into an empty block SHALL have rden_o high in the cycle after E0 and out_valid_o high after edge E0+2.
REQ-026 Throughput: with out_ready_i held high and the block non-empty, one word SHALL pop per cycle in steady state.
REQ-027 Ordering SHALL be strict FIFO; no word SHALL be lost or duplicated under any valid/ready pattern.
REQ-028 A read and a write SHALL never target the same address in the same cycle; this follows from REQ-018 and REQ-022.
REQ-029 Pointer wrap: after address DEPTH-1 the next address SHALL be 0.
REQ-030 When full (sram_cnt = DEPTH), in_ready_o=0 and in_valid_i SHALL be ignored; an issued read lets a push be accepted from the next cycle on.
REQ-031 count_o SHALL equal sram_cnt + inflight + obuf_cnt, registered.
REQ-032 in_ready_o SHALL NOT depend on out_ready_i; rden_o MAY depend on out_ready_i combinationally.

Reset
REQ-033 With rst_n low, asynchronously: wr_ptr=0, rd_ptr=0, sram_cnt=0, inflight=0, obuf_cnt=0, out_valid_o=0, count_o=0, in_ready_o=1; output buffer data SHALL be 0.
REQ-034 wren_o and rden_o SHALL be 0 while rst_n is low.
REQ-035 Reset mid-operation SHALL discard all contents; SRAM contents need not be cleared; the first word after release SHALL be written at address 0.

Verification (ADDR_WIDTH=2, DEPTH=4, DATA_WIDTH=16, SRAM model attached)
REQ-036 Single word: push 0x00A5 at E0 with out_ready_i=0 -> wren_o=1, wraddr_o=0 in the E0 cycle; rden_o=1, rdaddr_o=0 in the next cycle; out_valid_o=1, out_data_o=0x00A5 after E0+2; count_o=1 throughout.
REQ-037 Fill: out_ready_i=0, push 1..7 back-to-back -> 6 words accepted (2 in obuf, 4 in SRAM), in_ready_o=0, count_o=6; word 7 stalls until a pop occurs.
REQ-038 Streaming: in_valid_i=1 and out_ready_i=1 for 20 cycles with data 0..19 -> output 0..19 in order, one per cycle after the initial 2-cycle latency, count_o <= 3.
REQ-039 Wrap: 10 words with random valid/ready stalls -> addresses cycle 0,1,2,3,0,...; output order preserved; no read and write to the same address in one cycle.
REQ-040 Reset mid-stream: assert rst_n low with count_o=4 -> out_valid_o=0, count_o=0, in_ready_o=1 immediately; after release, first push writes address 0.
